// File: rtl/perf_monitor.sv
// Performance monitor: cycle, retired-instruction and generic event counters with sticky overflow and a snapshot shadow bank.
// Define PERF_SATURATE_EN to make counters stick at all-ones instead of wrapping.
module perf_monitor #(
    parameter int WIDTH       = 32,
    parameter int STATE_W     = 16,
    parameter int FETCH_STATE = 0,
    parameter int NUM_EVT     = 4,
    parameter int NCNT        = NUM_EVT + 2,
    parameter int SEL_W       = 4
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               enable,
    input  logic               clear,
    input  logic [STATE_W-1:0] state,
    input  logic [NUM_EVT-1:0] evt,
    input  logic               snap,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   rd_data,
    output logic [NCNT-1:0]    ovf,
    output logic               snap_valid
);

    logic             in_fetch;
    logic             is_fetch;
    logic [NCNT-1:0]  inc;
    logic [WIDTH-1:0] cnt    [NCNT];
    logic [WIDTH-1:0] shadow [NCNT];
    logic [WIDTH-1:0] rd_next;

    assign is_fetch = (state == STATE_W'(FETCH_STATE));

    // Index 0 = cycles, 1 = instructions (fetch entry edge), 2+i = event channel i.
    always_comb begin
        inc    = '0;
        inc[0] = enable;
        inc[1] = enable & is_fetch & ~in_fetch;
        for (int i = 0; i < NUM_EVT; i++) begin
            inc[i+2] = enable & evt[i];
        end
    end

    always_comb begin
        rd_next = '0;
        for (int n = 0; n < NCNT; n++) begin
            if (sel == SEL_W'(n)) begin
                rd_next = shadow[n];
            end
        end
    end

    // The tracker follows state even while counting is disabled, so a fetch entered while disabled is never counted later.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            in_fetch <= 1'b0;
        end else begin
            in_fetch <= is_fetch;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < NCNT; n++) begin
                cnt[n] <= '0;
            end
            ovf <= '0;
        end else if (clear) begin
            for (int n = 0; n < NCNT; n++) begin
                cnt[n] <= '0;
            end
            ovf <= '0;
        end else begin
            for (int n = 0; n < NCNT; n++) begin
                if (inc[n]) begin
                    if (cnt[n] == '1) begin
                        ovf[n] <= 1'b1;
                    end
`ifdef PERF_SATURATE_EN
                    if (cnt[n] != '1) begin
                        cnt[n] <= cnt[n] + WIDTH'(1);
                    end
`else
                    cnt[n] <= cnt[n] + WIDTH'(1);
`endif
                end
            end
        end
    end

    // Shadows survive clear; snap takes priority over clear for snap_valid.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < NCNT; n++) begin
                shadow[n] <= '0;
            end
            snap_valid <= 1'b0;
            rd_data    <= '0;
        end else begin
            if (snap) begin
                for (int n = 0; n < NCNT; n++) begin
                    shadow[n] <= cnt[n];
                end
                snap_valid <= 1'b1;
            end else if (clear) begin
                snap_valid <= 1'b0;
            end
            rd_data <= rd_next;
        end
    end

endmodule

// File: doc/perf_monitor.md
# perf_monitor

Parametrised performance monitor for the stage_7 memory-to-memory processor family. It counts elapsed cycles, retired instructions (entries into the fetch state), and NUM_EVT generic event channels. Counter width is configurable and every counter has a sticky overflow flag. A snapshot mechanism freezes all counters into a shadow bank that is read out through a registered select port. It sits beside the processor core, observing `state`, and replaces ad-hoc cycle and instruction counting in benches and on silicon.

## Interface
- WIDTH, 32: width of every counter, shadow register and rd_data.
- STATE_W, 16: width of the observed processor `state` bus.
- FETCH_STATE, 0: state encoding that marks instruction fetch.
- NUM_EVT, 4: number of generic event channels (1..14).
- NCNT, NUM_EVT+2: derived total counter count; not to be overridden.
- SEL_W, 4: width of `sel`; must satisfy 2^SEL_W ≥ NCNT.

- CLK  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  counting enable; counters hold when low.
- clear  in  1  synchronous clear of counters, overflow flags and snap_valid.
- state  in  STATE_W  current processor state.
- evt  in  NUM_EVT  per-channel event strobes; each high cycle counts once.
- snap  in  1  snapshot request; copies all live counters into the shadow bank.
- sel  in  SEL_W  shadow read select: 0 = cycles, 1 = instructions, 2+i = evt[i].
- rd_data  out  WIDTH  registered shadow[sel].
- ovf  out  NCNT  sticky overflow flags, same indexing as sel.
- snap_valid  out  1  high once a snapshot has been taken since reset/clear.

## Operation
- Reset (reset = 0, async): all counters, shadows, rd_data, ovf, snap_valid and the fetch tracker clear to 0.
- Fetch tracker `in_fetch` updates every cycle, whether or not `enable` is high: in_fetch <= (state == FETCH_STATE).
- Instruction counter increments when enable=1, state==FETCH_STATE and in_fetch==0.
  - A fetch state held for multiple cycles counts once.
  - The first fetch after reset counts.
  - Fetch entries that occur while enable is low are not counted and are not counted later.
- Cycle counter increments on every cycle with enable=1.
- Event counter i increments on every cycle with enable=1 and evt[i]=1.
- Overflow: an increment from all-ones sets ovf[n]=1. The flag stays set until clear or reset.
- Priority on a cycle with clear=1:
  - Clear wins over counting; all counters become 0 and no increment is applied on that cycle.
  - ovf and snap_valid become 0.
  - Shadows are NOT cleared.
- snap=1: shadow[n] <= live counter value before this edge's update, for all n simultaneously; snap_valid <= 1.
  - snap and clear on the same cycle: shadow captures pre-clear values, counters go to 0, and snap_valid ends at 1 (snap wins for snap_valid).
- Read path: rd_data <= (sel < NCNT) ? shadow[sel] : 0, registered every cycle.
- No state machine beyond the fetch tracker. The counters are free-running and independent.

## Timing
- Count latency: an event sampled at edge k is visible in the live counter after edge k.
- Snapshot: snap high at edge k captures the live values as they stood just before edge k. rd_data reflects the new shadow after edge k+1 (1-cycle read latency).
- A sel change at edge k is reflected on rd_data after edge k+1.
- Reset deassertion is asynchronous at the block; the first counted cycle is the first posedge with reset=1.
- Assertion of reset mid-count zeroes everything immediately, without waiting for a clock edge.

## Configuration
- PERF_SATURATE_EN defined: a counter at all-ones stays at all-ones on further increments; ovf is still set on the first blocked increment.
- PERF_SATURATE_EN undefined: counters wrap modulo 2^WIDTH (all-ones → 0) and set ovf.

## Test plan
- Reset, then enable=1 for 10 cycles with state toggling 0,1,2,0,1,2,0,1,2,0 → pulse snap, sel=0 → rd_data=10; sel=1 → rd_data=4.
- state held at FETCH_STATE for 5 cycles, then 3, then FETCH_STATE for 2 → instruction count 2, not 7.
- WIDTH=8, evt[0]=1 for 257 cycles:
  - with PERF_SATURATE_EN → shadow 255, ovf[2]=1;
  - without PERF_SATURATE_EN → shadow 1, ovf[2]=1.
- Counters at cycles=20, assert snap and clear together → shadow[0]=20, live counters 0, snap_valid=1, ovf=0. A snap 5 cycles later reads 5.
- enable=0 for 6 cycles with a fetch entry and evt[1] pulses inside the window → no counter changes. After re-enable, a fetch state already active is not counted.
- Assert reset low mid-count (asynchronously, between edges) → rd_data, ovf and snap_valid are 0 immediately. sel=NCNT (out of range) after recovery → rd_data=0.
